// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the main rail power sequencer: state encoding,
// PSU fault code, tick timer width and a lowest-set-bit helper.
package pwr_seq_pkg;

    localparam int         TMR_W    = 8;
    localparam logic [3:0] FIDX_PSU = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PSU_ON  = 3'd1,
        ST_RAIL_UP = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ON      = 3'd4,
        ST_RAIL_DN = 3'd5,
        ST_FAULT   = 3'd6
    } seq_state_e;

    // Position of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set(input logic [7:0] vec);
        logic [3:0] pos;
        pos = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) pos = 4'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/seq_ms_timer.sv
// Saturating 8-bit millisecond tick counter with synchronous clear and
// terminal-count compare against a caller-supplied limit.
module seq_ms_timer
    import pwr_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             tick,
    input  logic [TMR_W-1:0] limit,
    output logic             expire
);

    logic [TMR_W-1:0] count;
    logic [TMR_W:0]   count_inc;

    assign count_inc = {1'b0, count} + (TMR_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick && (count != {TMR_W{1'b1}})) begin
            count <= count_inc[TMR_W-1:0];
        end
    end

    // High on the tick that brings the count up to the limit.
    assign expire = tick && (count_inc >= {1'b0, limit});

endmodule

// File: rtl/main_rail_seq.sv
// Main rail power sequencer: PSU enable, ordered rail ramp with settle time,
// reverse ramp-down and latched faults. Define PWRGD_TIMEOUT_EN for power-good timeouts.
//
// state    | meaning
// IDLE     | everything off, waiting for pwr_req
// PSU_ON   | ps_en high, waiting for ps_pwrok
// RAIL_UP  | rail idx enabled, waiting for its power good
// SETTLE   | rail idx good, waiting DELAY_MS ticks
// ON       | all rails up, sys_pwrok high, monitoring
// RAIL_DN  | orderly shutdown, highest rail first
// FAULT    | everything off, fault latched until pwr_req drops
module main_rail_seq
    import pwr_seq_pkg::*;
#(
    parameter int NUM_RAILS  = 4,
    parameter int DELAY_MS   = 2,
    parameter int TIMEOUT_MS = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnt1ms_done,
    input  logic                 pwr_req,
    input  logic                 ps_pwrok,
    input  logic [NUM_RAILS-1:0] rail_pg,
    output logic                 ps_en,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 sys_pwrok,
    output logic                 fault,
    output logic [3:0]           fault_idx,
    output logic [2:0]           seq_state
);

    localparam logic [2:0]       IDX_LAST = 3'(NUM_RAILS - 1);
    localparam logic [TMR_W-1:0] DLY_LIM  = TMR_W'(DELAY_MS);
    localparam logic [TMR_W-1:0] TO_LIM   = TMR_W'(TIMEOUT_MS);

    seq_state_e           state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
    logic                 ps_en_q, ps_en_d;
    logic                 sys_pwrok_q, sys_pwrok_d;
    logic                 fault_q, fault_d;
    logic [3:0]           fault_idx_q, fault_idx_d;

    logic                 go_fault, go_dn;
    logic [3:0]           fault_code;
    logic                 tmr_clr, tmr_expire, pg_timeout, cur_pg;
    logic [TMR_W-1:0]     tmr_limit;
    logic [NUM_RAILS-1:0] idx_oh, fail_vec;

    assign idx_oh    = NUM_RAILS'(1) << idx_q;
    assign cur_pg    = |(rail_pg & idx_oh);
    // Only enabled rails can report a runtime loss.
    assign fail_vec  = rail_en_q & ~rail_pg;
    assign tmr_limit = (state_q == ST_SETTLE || state_q == ST_RAIL_DN) ? DLY_LIM : TO_LIM;
    assign tmr_clr   = (state_d != state_q) || (idx_d != idx_q);

`ifdef PWRGD_TIMEOUT_EN
    assign pg_timeout = tmr_expire;
`else
    assign pg_timeout = 1'b0;
`endif

    seq_ms_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .tick   (cnt1ms_done),
        .limit  (tmr_limit),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rail_en_d   = rail_en_q;
        ps_en_d     = ps_en_q;
        sys_pwrok_d = sys_pwrok_q;
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;
        go_fault    = 1'b0;
        go_dn       = 1'b0;
        fault_code  = FIDX_PSU;

        case (state_q)
            ST_IDLE: begin
                if (pwr_req) begin
                    state_d = ST_PSU_ON;
                    ps_en_d = 1'b1;
                    idx_d   = 3'd0;
                end
            end
            ST_PSU_ON: begin
                if (!ps_pwrok && pg_timeout) begin
                    go_fault   = 1'b1;
                    fault_code = FIDX_PSU;
                end else if (!pwr_req) begin
                    go_dn = 1'b1;
                end else if (ps_pwrok) begin
                    state_d   = ST_RAIL_UP;
                    idx_d     = 3'd0;
                    rail_en_d = rail_en_q | NUM_RAILS'(1);
                end
            end
            ST_RAIL_UP: begin
                if (!cur_pg && pg_timeout) begin
                    go_fault   = 1'b1;
                    fault_code = {1'b0, idx_q};
                end else if (!pwr_req) begin
                    go_dn = 1'b1;
                end else if (cur_pg) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!pwr_req) begin
                    go_dn = 1'b1;
                end else if (tmr_expire) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = ST_ON;
                        sys_pwrok_d = 1'b1;
                    end else begin
                        state_d   = ST_RAIL_UP;
                        idx_d     = idx_q + 3'd1;
                        rail_en_d = rail_en_q | (idx_oh << 1);
                    end
                end
            end
            ST_ON: begin
                if (!ps_pwrok) begin
                    go_fault   = 1'b1;
                    fault_code = FIDX_PSU;
                end else if (|fail_vec) begin
                    go_fault   = 1'b1;
                    fault_code = lowest_set(8'(fail_vec));
                end else if (!pwr_req) begin
                    go_dn = 1'b1;
                end
            end
            ST_RAIL_DN: begin
                // idx tracks the highest rail still enabled; pwr_req is ignored here.
                if (rail_en_q == '0) begin
                    state_d = ST_IDLE;
                    ps_en_d = 1'b0;
                end else if (tmr_expire) begin
                    rail_en_d = rail_en_q & ~idx_oh;
                    if (idx_q != 3'd0) idx_d = idx_q - 3'd1;
                end
            end
            ST_FAULT: begin
                if (!pwr_req) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_dn) begin
            state_d     = ST_RAIL_DN;
            sys_pwrok_d = 1'b0;
        end

        if (go_fault) begin
            state_d     = ST_FAULT;
            ps_en_d     = 1'b0;
            rail_en_d   = '0;
            sys_pwrok_d = 1'b0;
            fault_d     = 1'b1;
            fault_idx_d = fault_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            rail_en_q   <= '0;
            ps_en_q     <= 1'b0;
            sys_pwrok_q <= 1'b0;
            fault_q     <= 1'b0;
            fault_idx_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rail_en_q   <= rail_en_d;
            ps_en_q     <= ps_en_d;
            sys_pwrok_q <= sys_pwrok_d;
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
        end
    end

    assign ps_en     = ps_en_q;
    assign rail_en   = rail_en_q;
    assign sys_pwrok = sys_pwrok_q;
    assign fault     = fault_q;
    assign fault_idx = fault_idx_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_main_rail_seq.sv
// Self-checking bench for main_rail_seq: directed scenarios plus randomized
// traffic compared against a rail-count based behavioural model.
module tb_main_rail_seq;

    localparam int N       = 4;
    localparam int DLY     = 2;
    localparam int TMO     = 10;
`ifdef PWRGD_TIMEOUT_EN
    localparam bit TO_EN   = 1'b1;
`else
    localparam bit TO_EN   = 1'b0;
`endif

    localparam int P_IDLE = 0, P_PSU = 1, P_UP = 2, P_SET = 3, P_ON = 4, P_DN = 5, P_FLT = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cnt1ms_done = 1'b0;
    logic         pwr_req = 1'b0;
    logic         ps_pwrok = 1'b0;
    logic [N-1:0] rail_pg = '0;
    logic         ps_en;
    logic [N-1:0] rail_en;
    logic         sys_pwrok;
    logic         fault;
    logic [3:0]   fault_idx;
    logic [2:0]   seq_state;

    int errors = 0;
    int checks = 0;

    main_rail_seq #(.NUM_RAILS(N), .DELAY_MS(DLY), .TIMEOUT_MS(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt1ms_done (cnt1ms_done),
        .pwr_req     (pwr_req),
        .ps_pwrok    (ps_pwrok),
        .rail_pg     (rail_pg),
        .ps_en       (ps_en),
        .rail_en     (rail_en),
        .sys_pwrok   (sys_pwrok),
        .fault       (fault),
        .fault_idx   (fault_idx),
        .seq_state   (seq_state)
    );

    always #5 clk = ~clk;

    // Reference model: tracks how many rails are on and ticks spent in the current step.
    int m_phase = P_IDLE, m_n = 0, m_ticks = 0, m_fidx = 0;
    bit m_psen = 0, m_pwrok = 0, m_fault = 0;

    always @(posedge clk) begin
        int  nt, low;
        bit  to_hit, dly_hit;
        if (!rst_n) begin
            m_phase = P_IDLE; m_n = 0; m_ticks = 0; m_fidx = 0;
            m_psen = 0; m_pwrok = 0; m_fault = 0;
        end else begin
            nt      = (cnt1ms_done && m_ticks < 255) ? m_ticks + 1 : m_ticks;
            to_hit  = TO_EN && cnt1ms_done && (m_ticks + 1 >= TMO);
            dly_hit = cnt1ms_done && (m_ticks + 1 >= DLY);
            low = -1;
            for (int i = m_n - 1; i >= 0; i--) if (!rail_pg[i]) low = i;
            case (m_phase)
                P_IDLE: if (pwr_req) begin m_phase = P_PSU; m_ticks = 0; m_psen = 1; end
                P_PSU: begin
                    if (!ps_pwrok && to_hit) begin
                        m_phase = P_FLT; m_psen = 0; m_n = 0; m_pwrok = 0; m_fault = 1; m_fidx = 15;
                    end else if (!pwr_req) begin m_phase = P_DN; m_ticks = 0; m_pwrok = 0; end
                    else if (ps_pwrok) begin m_phase = P_UP; m_ticks = 0; m_n = 1; end
                    else m_ticks = nt;
                end
                P_UP: begin
                    if (!rail_pg[m_n-1] && to_hit) begin
                        m_phase = P_FLT; m_fidx = m_n - 1; m_psen = 0; m_n = 0; m_pwrok = 0; m_fault = 1;
                    end else if (!pwr_req) begin m_phase = P_DN; m_ticks = 0; m_pwrok = 0; end
                    else if (rail_pg[m_n-1]) begin m_phase = P_SET; m_ticks = 0; end
                    else m_ticks = nt;
                end
                P_SET: begin
                    if (!pwr_req) begin m_phase = P_DN; m_ticks = 0; m_pwrok = 0; end
                    else if (dly_hit) begin
                        m_ticks = 0;
                        if (m_n < N) begin m_n++; m_phase = P_UP; end
                        else begin m_phase = P_ON; m_pwrok = 1; end
                    end else m_ticks = nt;
                end
                P_ON: begin
                    if (!ps_pwrok || low >= 0) begin
                        m_fidx = !ps_pwrok ? 15 : low;
                        m_phase = P_FLT; m_psen = 0; m_n = 0; m_pwrok = 0; m_fault = 1;
                    end else if (!pwr_req) begin m_phase = P_DN; m_ticks = 0; m_pwrok = 0; end
                end
                P_DN: begin
                    if (m_n == 0) begin m_phase = P_IDLE; m_ticks = 0; m_psen = 0; end
                    else if (dly_hit) begin m_n--; m_ticks = 0; end
                    else m_ticks = nt;
                end
                default: if (!pwr_req) begin m_phase = P_IDLE; m_ticks = 0; m_fault = 0; end
            endcase
        end
    end

    task automatic step(input bit tk);
        cnt1ms_done = tk;
        @(negedge clk);
        cnt1ms_done = 1'b0;
    endtask

    task automatic clear_inputs();
        pwr_req = 0; ps_pwrok = 0; rail_pg = '0; cnt1ms_done = 0;
    endtask

    task automatic power_up();
        pwr_req = 1; step(0);
        ps_pwrok = 1; step(0);
        for (int i = 0; i < N; i++) begin
            rail_pg[i] = 1'b1; step(0); step(1); step(1);
        end
        checks++;
        if ({seq_state, sys_pwrok, rail_en} !== {3'd4, 1'b1, 4'b1111}) begin
            errors++; $display("FAIL power_up_on got=%b exp=%b", {seq_state, sys_pwrok, rail_en}, {3'd4, 1'b1, 4'b1111});
        end
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs(); step(0); step(0);
        checks++;
        if ({ps_en, rail_en, sys_pwrok, fault, fault_idx, seq_state} !== 14'd0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0", {ps_en, rail_en, sys_pwrok, fault, fault_idx, seq_state});
        end
        rst_n = 1; step(1);
        checks++;
        if ({ps_en, seq_state} !== 4'd0) begin
            errors++; $display("FAIL reset_idle_hold got=%b exp=0", {ps_en, seq_state});
        end
    endtask

    task automatic test_nominal();
        pwr_req = 1; step(0);
        checks++;
        if ({ps_en, seq_state, rail_en} !== {1'b1, 3'd1, 4'b0000}) begin
            errors++; $display("FAIL nominal_psu_on got=%b exp=%b", {ps_en, seq_state, rail_en}, {1'b1, 3'd1, 4'b0000});
        end
        step(1); step(1); step(1);
        ps_pwrok = 1; step(0);
        checks++;
        if ({seq_state, rail_en} !== {3'd2, 4'b0001}) begin
            errors++; $display("FAIL nominal_rail0_en got=%b exp=%b", {seq_state, rail_en}, {3'd2, 4'b0001});
        end
        step(1);
        rail_pg[0] = 1; step(0); step(1); step(1);
        checks++;
        if ({seq_state, rail_en} !== {3'd2, 4'b0011}) begin
            errors++; $display("FAIL nominal_rail1_en got=%b exp=%b", {seq_state, rail_en}, {3'd2, 4'b0011});
        end
        // rail 1 good arrives with a tick: that tick must not count toward settle
        rail_pg[1] = 1; step(1); step(1);
        checks++;
        if ({seq_state, rail_en} !== {3'd3, 4'b0011}) begin
            errors++; $display("FAIL settle_tick_on_change got=%b exp=%b", {seq_state, rail_en}, {3'd3, 4'b0011});
        end
        step(1);
        checks++;
        if ({seq_state, rail_en} !== {3'd2, 4'b0111}) begin
            errors++; $display("FAIL nominal_rail2_en got=%b exp=%b", {seq_state, rail_en}, {3'd2, 4'b0111});
        end
        rail_pg[2] = 1; step(0); step(1); step(1);
        checks++;
        if (rail_en !== 4'b1111) begin
            errors++; $display("FAIL nominal_rail3_en got=%b exp=1111", rail_en);
        end
        rail_pg[3] = 1; step(0); step(1);
        checks++;
        if (sys_pwrok !== 1'b0) begin
            errors++; $display("FAIL nominal_pwrok_early got=%b exp=0", sys_pwrok);
        end
        step(1);
        checks++;
        if ({sys_pwrok, seq_state, ps_en, rail_en} !== {1'b1, 3'd4, 1'b1, 4'b1111}) begin
            errors++; $display("FAIL nominal_on got=%b exp=%b", {sys_pwrok, seq_state, ps_en, rail_en}, {1'b1, 3'd4, 1'b1, 4'b1111});
        end
    endtask

    task automatic test_runtime_loss();
        rail_pg[1] = 0; step(0);
        checks++;
        if ({fault, fault_idx, sys_pwrok, ps_en, rail_en, seq_state} !== {1'b1, 4'd1, 1'b0, 1'b0, 4'b0000, 3'd6}) begin
            errors++; $display("FAIL runtime_loss_fault got=%b exp=%b", {fault, fault_idx, sys_pwrok, ps_en, rail_en, seq_state}, {1'b1, 4'd1, 1'b0, 1'b0, 4'b0000, 3'd6});
        end
        step(1);
        checks++;
        if ({fault, seq_state} !== {1'b1, 3'd6}) begin
            errors++; $display("FAIL runtime_loss_hold got=%b exp=%b", {fault, seq_state}, {1'b1, 3'd6});
        end
        pwr_req = 0; step(0);
        checks++;
        if ({fault, fault_idx, seq_state} !== {1'b0, 4'd1, 3'd0}) begin
            errors++; $display("FAIL runtime_loss_release got=%b exp=%b", {fault, fault_idx, seq_state}, {1'b0, 4'd1, 3'd0});
        end
        clear_inputs(); step(0);
    endtask

    task automatic test_simultaneous();
        power_up();
        ps_pwrok = 0; pwr_req = 0; step(0);
        checks++;
        if ({fault, fault_idx, seq_state, ps_en} !== {1'b1, 4'd15, 3'd6, 1'b0}) begin
            errors++; $display("FAIL simult_fault_wins got=%b exp=%b", {fault, fault_idx, seq_state, ps_en}, {1'b1, 4'd15, 3'd6, 1'b0});
        end
        step(0);
        checks++;
        if ({fault, fault_idx, seq_state} !== {1'b0, 4'd15, 3'd0}) begin
            errors++; $display("FAIL simult_release got=%b exp=%b", {fault, fault_idx, seq_state}, {1'b0, 4'd15, 3'd0});
        end
        clear_inputs(); step(0);
    endtask

    task automatic test_abort();
        pwr_req = 1; step(0);
        ps_pwrok = 1; step(0);
        rail_pg[0] = 1; step(0); step(1); step(1);
        pwr_req = 0; step(0);
        checks++;
        if ({seq_state, rail_en, sys_pwrok, ps_en} !== {3'd5, 4'b0011, 1'b0, 1'b1}) begin
            errors++; $display("FAIL abort_enter_dn got=%b exp=%b", {seq_state, rail_en, sys_pwrok, ps_en}, {3'd5, 4'b0011, 1'b0, 1'b1});
        end
        pwr_req = 1;
        step(1); step(1);
        checks++;
        if (rail_en !== 4'b0001) begin
            errors++; $display("FAIL abort_first_off got=%b exp=0001", rail_en);
        end
        step(1); step(1);
        checks++;
        if ({rail_en, ps_en, seq_state} !== {4'b0000, 1'b1, 3'd5}) begin
            errors++; $display("FAIL abort_all_off got=%b exp=%b", {rail_en, ps_en, seq_state}, {4'b0000, 1'b1, 3'd5});
        end
        step(0);
        checks++;
        if ({ps_en, seq_state} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL abort_idle got=%b exp=%b", {ps_en, seq_state}, {1'b0, 3'd0});
        end
        step(0);
        checks++;
        if ({ps_en, seq_state} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL abort_rereq_after_idle got=%b exp=%b", {ps_en, seq_state}, {1'b1, 3'd1});
        end
        rst_n = 0; clear_inputs(); step(0); rst_n = 1; step(0);
    endtask

    task automatic test_timeout();
`ifdef PWRGD_TIMEOUT_EN
        pwr_req = 1; step(0);
        for (int i = 0; i < TMO - 1; i++) step(1);
        checks++;
        if ({fault, seq_state} !== {1'b0, 3'd1}) begin
            errors++; $display("FAIL psu_timeout_early got=%b exp=%b", {fault, seq_state}, {1'b0, 3'd1});
        end
        step(1);
        checks++;
        if ({fault, fault_idx, ps_en} !== {1'b1, 4'd15, 1'b0}) begin
            errors++; $display("FAIL psu_timeout got=%b exp=%b", {fault, fault_idx, ps_en}, {1'b1, 4'd15, 1'b0});
        end
        pwr_req = 0; step(0);
        pwr_req = 1; step(0);
        ps_pwrok = 1; step(0);
        rail_pg[0] = 1; step(0); step(1); step(1);
        rail_pg[1] = 1; step(0); step(1); step(1);
        for (int i = 0; i < TMO - 1; i++) step(1);
        checks++;
        if ({fault, seq_state, rail_en} !== {1'b0, 3'd2, 4'b0111}) begin
            errors++; $display("FAIL rail_timeout_early got=%b exp=%b", {fault, seq_state, rail_en}, {1'b0, 3'd2, 4'b0111});
        end
        step(1);
        checks++;
        if ({fault, fault_idx, ps_en, rail_en} !== {1'b1, 4'd2, 1'b0, 4'b0000}) begin
            errors++; $display("FAIL rail_timeout got=%b exp=%b", {fault, fault_idx, ps_en, rail_en}, {1'b1, 4'd2, 1'b0, 4'b0000});
        end
`else
        pwr_req = 1; step(0);
        ps_pwrok = 1; step(0);
        for (int i = 0; i < 300; i++) step(1);
        checks++;
        if ({fault, seq_state, rail_en, ps_en} !== {1'b0, 3'd2, 4'b0001, 1'b1}) begin
            errors++; $display("FAIL no_timeout_wait got=%b exp=%b", {fault, seq_state, rail_en, ps_en}, {1'b0, 3'd2, 4'b0001, 1'b1});
        end
`endif
        rst_n = 0; clear_inputs(); step(0); rst_n = 1; step(0);
    endtask

    task automatic test_reset_midramp();
        pwr_req = 1; step(0);
        ps_pwrok = 1; step(0);
        rail_pg[0] = 1; step(0); step(1); step(1);
        rail_pg[1] = 1; step(0); step(1); step(1);
        rail_pg[2] = 1; step(0); step(1);
        checks++;
        if ({seq_state, rail_en} !== {3'd3, 4'b0111}) begin
            errors++; $display("FAIL midramp_settle got=%b exp=%b", {seq_state, rail_en}, {3'd3, 4'b0111});
        end
        rst_n = 0; step(0);
        checks++;
        if ({ps_en, rail_en, sys_pwrok, fault, fault_idx, seq_state} !== 14'd0) begin
            errors++; $display("FAIL midramp_reset got=%b exp=0", {ps_en, rail_en, sys_pwrok, fault, fault_idx, seq_state});
        end
        clear_inputs(); rst_n = 1; step(0);
    endtask

    task automatic test_random();
        logic [13:0] got, exp;
        rst_n = 0; clear_inputs(); step(0); rst_n = 1; pwr_req = 1;
        for (int c = 0; c < 4000; c++) begin
            got = {ps_en, rail_en, sys_pwrok, fault, fault_idx, seq_state};
            exp = {m_psen, 4'((1 << m_n) - 1), m_pwrok, m_fault, 4'(m_fidx), 3'(m_phase)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_cycle_%0d got=%b exp=%b", c, got, exp);
            end
            rst_n = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 69) == 0) pwr_req = ~pwr_req;
            cnt1ms_done = ($urandom_range(0, 2) == 0);
            if (!ps_en) ps_pwrok = ($urandom_range(0, 99) == 0);
            else if (!ps_pwrok) ps_pwrok = ($urandom_range(0, 3) == 0);
            else ps_pwrok = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < N; i++) begin
                if (!rail_en[i]) rail_pg[i] = ($urandom_range(0, 29) == 0);
                else if (!rail_pg[i]) rail_pg[i] = ($urandom_range(0, 3) == 0);
                else rail_pg[i] = ($urandom_range(0, 399) != 0);
            end
            @(negedge clk);
        end
        cnt1ms_done = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_runtime_loss();
        test_simultaneous();
        test_abort();
        test_timeout();
        test_reset_midramp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/main_rail_seq.md
MAIN_RAIL_SEQ -- requirements
Module: main_rail_seq

Interface
REQ-001 SHALL have parameter NUM_RAILS, default 4, number of sequenced main rails (2..8).
REQ-002 SHALL have parameter DELAY_MS, default 2, settle time in ms ticks after each rail good (1..15).
REQ-003 SHALL have parameter TIMEOUT_MS, default 100, maximum ms ticks allowed for any power-good to arrive (1..255).
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-005 Ports SHALL be:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- cnt1ms_done  input  1  one-cycle 1 ms tick
- pwr_req  input  1  level power-on request (decoded pson)
- ps_pwrok  input  1  PSU power good
- rail_pg  input  NUM_RAILS  per-rail power good, index 0 first up
- ps_en  output  1  PSU enable
- rail_en  output  NUM_RAILS  per-rail enable
- sys_pwrok  output  1  all rails up and settled
- fault  output  1  sequencing fault latched
- fault_idx  output  4  failing stage: 0..NUM_RAILS-1 rail, 15 PSU
- seq_state  output  3  encoded FSM state for debug

Function
REQ-006 All outputs SHALL be registered; every transition SHALL take effect on outputs one clk after the qualifying input.
REQ-007 FSM states SHALL be IDLE, PSU_ON, RAIL_UP, SETTLE, ON, RAIL_DN, FAULT.
REQ-008 IDLE: pwr_req=1 -> PSU_ON, ps_en=1.
REQ-009 PSU_ON: ps_pwrok=1 -> RAIL_UP with idx=0; TIMEOUT_MS ticks without ps_pwrok -> FAULT, fault_idx=15.
REQ-010 RAIL_UP: rail_en[idx]=1 (lower rails held on); rail_pg[idx]=1 -> SETTLE; TIMEOUT_MS ticks without it -> FAULT, fault_idx=idx.
REQ-011 SETTLE: after DELAY_MS ticks, idx<NUM_RAILS-1 -> idx+1, RAIL_UP; idx=NUM_RAILS-1 -> ON.
REQ-012 ON: sys_pwrok=1; loss of ps_pwrok or any enabled rail_pg -> FAULT (fault_idx = lowest failing rail, 15 if PSU).
REQ-013 pwr_req=0 in PSU_ON, RAIL_UP, SETTLE or ON -> RAIL_DN; sys_pwrok=0 on entry.
REQ-014 RAIL_DN: clear highest enabled rail each DELAY_MS ticks, reverse order; when none left, ps_en=0, -> IDLE.
REQ-015 pwr_req reasserted during RAIL_DN SHALL be ignored until IDLE is reached.
REQ-016 FAULT: ps_en=0, rail_en=0, sys_pwrok=0, fault=1 in the same update; hold until pwr_req=0, then -> IDLE with fault=0 and fault_idx retained.
REQ-017 Tick timer SHALL be 8 bits, count only cnt1ms_done, clear on every state or idx change; clear wins over coincident tick; saturate, never wrap.
REQ-018 Fault conditions SHALL have priority over pwr_req=0 in the same cycle.
REQ-019 rail_pg for rails not yet enabled SHALL be ignored.

Reset
REQ-020 rst_n=0 SHALL force IDLE, idx=0, timer=0, ps_en=0, rail_en=0, sys_pwrok=0, fault=0, fault_idx=0, seq_state=0, at the next clk edge, from any state including mid-ramp.

Configuration
REQ-021 With PWRGD_TIMEOUT_EN defined, REQ-009/REQ-010 timeouts SHALL be active; without it, PSU_ON and RAIL_UP SHALL wait indefinitely and fault SHALL arise only per REQ-012.

Structure
REQ-022 State enum, fault_idx PSU code (15) and timer width SHALL live in shared package pwr_seq_pkg.
REQ-023 Tick timer SHALL be sub-module seq_ms_timer (clear, tick, count, terminal-compare); FSM stays in main_rail_seq.

Verification (NUM_RAILS=4, DELAY_MS=2, TIMEOUT_MS=10)
REQ-024 Nominal up: pwr_req=1, ps_pwrok 3 ticks later, each rail_pg 1 tick after its enable -> rail_en walks 0001..1111, sys_pwrok=1 2 ticks after rail_pg[3].
REQ-025 Rail timeout: rail_pg[2] never rises -> after 10 ticks fault=1, fault_idx=2, all enables 0 next clk.
REQ-026 Ramp abort: pwr_req=0 while rail_en=0011 -> rail_en 0001 after 2 ticks, 0000 after 4, then ps_en=0, IDLE.
REQ-027 Runtime loss: in ON drop rail_pg[1] -> fault=1, fault_idx=1, sys_pwrok=0 one clk later; pwr_req=0 -> fault=0, IDLE.
REQ-028 Simultaneity: ps_pwrok drop and pwr_req=0 same cycle in ON -> FAULT, fault_idx=15; tick on idx-change cycle not counted.
REQ-029 rst_n=0 during SETTLE of rail 2 -> all outputs 0 next clk; build without PWRGD_TIMEOUT_EN -> 300 ticks missing rail_pg[0], fault stays 0.
